d_mem_dp_param: RTL and testbench

Parametrised true-dual-port data memory. It is the next-generation core/fabric data store.
- Configurable data width, depth, read latency and read-during-write mode.
- Byte-enable writes on both ports, with deterministic same-address write-collision resolution.
- Read-data valid strobes, out-of-range detection and a saturating collision counter.
- Port A serves the core; port B serves the fabric.

---
 rtl/d_mem_dp_param_if.sv | 49 ++++
 rtl/d_mem_dp_param.sv | 136 +++++++++++++
 tb/tb_d_mem_dp_param.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/d_mem_dp_param_if.sv
// Dual-port data memory bus: core side on port A, fabric side on port B.
// Collision counter controls travel with the bus.
interface d_mem_dp_param_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
);
    localparam int BE_W   = DATA_W / 8;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] address_a;
    logic [BE_W-1:0]   byteena_a;
    logic [DATA_W-1:0] data_a;
    logic              rden_a;
    logic              wren_a;
    logic [DATA_W-1:0] q_a;
    logic              q_valid_a;
    logic              err_a;

    logic [ADDR_W-1:0] address_b;
    logic [BE_W-1:0]   byteena_b;
    logic [DATA_W-1:0] data_b;
    logic              rden_b;
    logic              wren_b;
    logic [DATA_W-1:0] q_b;
    logic              q_valid_b;
    logic              err_b;

    logic              clr_coll_cnt;
    logic              coll_pulse;
    logic [15:0]       coll_cnt;

    modport master (
        output address_a, byteena_a, data_a, rden_a, wren_a,
        output address_b, byteena_b, data_b, rden_b, wren_b,
        output clr_coll_cnt,
        input  q_a, q_valid_a, err_a,
        input  q_b, q_valid_b, err_b,
        input  coll_pulse, coll_cnt
    );

    modport slave (
        input  address_a, byteena_a, data_a, rden_a, wren_a,
        input  address_b, byteena_b, data_b, rden_b, wren_b,
        input  clr_coll_cnt,
        output q_a, q_valid_a, err_a,
        output q_b, q_valid_b, err_b,
        output coll_pulse, coll_cnt
    );
endinterface

// File: rtl/d_mem_dp_param.sv
// True-dual-port byte-enable data memory with collision resolution,
// configurable read latency and read-during-write behaviour.
module d_mem_dp_param #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int RD_LAT  = 1,
    parameter int RDW_NEW = 0,
    parameter int PRIO_B  = 0
) (
    input logic             clock,
    input logic             rst_n,
    d_mem_dp_param_if.slave bus
);
    localparam int BE_W   = DATA_W / 8;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    word_t           mem [DEPTH];
    addr_t           addr [2];
    logic [BE_W-1:0] be [2];
    word_t           wdata [2];
    logic            rden [2];
    logic            wren [2];
    logic            ok [2];
    logic            wr_ok [2];
    word_t           cur [2];
    word_t           nw [2];
    logic            coll;

    logic            v1 [2];
    logic            er1 [2];
    logic            ew1 [2];
    word_t           d1 [2];
    logic            v2 [2];
    logic            er2 [2];
    word_t           d2 [2];
    logic            coll_q;
    logic [15:0]     cnt;

    assign addr[0]  = bus.address_a;
    assign addr[1]  = bus.address_b;
    assign be[0]    = bus.byteena_a;
    assign be[1]    = bus.byteena_b;
    assign wdata[0] = bus.data_a;
    assign wdata[1] = bus.data_b;
    assign rden[0]  = bus.rden_a;
    assign rden[1]  = bus.rden_b;
    assign wren[0]  = bus.wren_a;
    assign wren[1]  = bus.wren_b;

    // nw[p] is the word at addr[p] after this edge's writes from both ports
    always_comb begin
        logic hit_a;
        logic hit_b;
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int p = 0; p < 2; p++) begin
            ok[p]    = 32'(addr[p]) < 32'(DEPTH);
            wr_ok[p] = wren[p] && ok[p];
            cur[p]   = ok[p] ? mem[addr[p]] : '0;
        end
        for (int p = 0; p < 2; p++) begin
            nw[p] = cur[p];
            for (int i = 0; i < BE_W; i++) begin
                hit_a = wr_ok[0] && (addr[0] == addr[p]) && be[0][i];
                hit_b = wr_ok[1] && (addr[1] == addr[p]) && be[1][i];
                if (hit_a && !(hit_b && PRIO_B != 0))
                    nw[p][8*i +: 8] = wdata[0][8*i +: 8];
                else if (hit_b)
                    nw[p][8*i +: 8] = wdata[1][8*i +: 8];
            end
        end
    end

    assign coll = wr_ok[0] && wr_ok[1] && (addr[0] == addr[1])
                  && (|(be[0] & be[1]));

    // Same-address writes from both ports carry the identical merged word
    always_ff @(posedge clock) begin
        for (int p = 0; p < 2; p++) begin
            if (wr_ok[p])
                mem[addr[p]] <= nw[p];
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                v1[p]  <= 1'b0;
                er1[p] <= 1'b0;
                ew1[p] <= 1'b0;
                d1[p]  <= '0;
                v2[p]  <= 1'b0;
                er2[p] <= 1'b0;
                d2[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                v1[p]  <= rden[p];
                er1[p] <= rden[p] && !ok[p];
                ew1[p] <= wren[p] && !rden[p] && !ok[p];
                if (rden[p])
                    d1[p] <= (RDW_NEW != 0) ? nw[p] : cur[p];
                v2[p]  <= v1[p];
                er2[p] <= er1[p];
                if (v1[p])
                    d2[p] <= d1[p];
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
            cnt    <= '0;
        end else begin
            coll_q <= coll;
            if (bus.clr_coll_cnt)
                cnt <= '0;
            else if (coll && cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
        end
    end

    // Write-only range errors always report one edge after the write
    assign bus.q_a       = (RD_LAT == 2) ? d2[0] : d1[0];
    assign bus.q_valid_a = (RD_LAT == 2) ? v2[0] : v1[0];
    assign bus.err_a     = ((RD_LAT == 2) ? er2[0] : er1[0]) | ew1[0];
    assign bus.q_b       = (RD_LAT == 2) ? d2[1] : d1[1];
    assign bus.q_valid_b = (RD_LAT == 2) ? v2[1] : v1[1];
    assign bus.err_b     = ((RD_LAT == 2) ? er2[1] : er1[1]) | ew1[1];
    assign bus.coll_pulse = coll_q;
    assign bus.coll_cnt   = cnt;
endmodule

// File: tb/tb_d_mem_dp_param.sv
// Bench for d_mem_dp_param: a vector table on a 1-cycle/old-data/A-wins
// instance, hand sequences on a 2-cycle/new-data/B-wins instance.
module tb_d_mem_dp_param;
    logic clk = 1'b0;
    logic r0 = 1'b0;
    logic r1 = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    d_mem_dp_param_if #(.DATA_W(32), .DEPTH(1000)) b0 ();
    d_mem_dp_param_if #(.DATA_W(32), .DEPTH(1024)) b1 ();

    d_mem_dp_param #(
        .DATA_W(32), .DEPTH(1000), .RD_LAT(1), .RDW_NEW(0), .PRIO_B(0)
    ) u0 (.clock(clk), .rst_n(r0), .bus(b0.slave));

    d_mem_dp_param #(
        .DATA_W(32), .DEPTH(1024), .RD_LAT(2), .RDW_NEW(1), .PRIO_B(1)
    ) u1 (.clock(clk), .rst_n(r1), .bus(b1.slave));

    typedef struct {
        logic        clr;
        logic        wa;
        logic        ra;
        logic [9:0]  aa;
        logic [3:0]  bea;
        logic [31:0] da;
        logic        wb;
        logic        rb;
        logic [9:0]  ab;
        logic [3:0]  beb;
        logic [31:0] db;
        logic [31:0] eqa;
        logic        eva;
        logic        eea;
        logic [31:0] eqb;
        logic        evb;
        logic        eeb;
        logic        ecp;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vt [23];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        b0.address_a = '0; b0.byteena_a = '0; b0.data_a = '0;
        b0.rden_a = 0; b0.wren_a = 0;
        b0.address_b = '0; b0.byteena_b = '0; b0.data_b = '0;
        b0.rden_b = 0; b0.wren_b = 0; b0.clr_coll_cnt = 0;
        b1.address_a = '0; b1.byteena_a = '0; b1.data_a = '0;
        b1.rden_a = 0; b1.wren_a = 0;
        b1.address_b = '0; b1.byteena_b = '0; b1.data_b = '0;
        b1.rden_b = 0; b1.wren_b = 0; b1.clr_coll_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic put0(input vec_t v);
        b0.clr_coll_cnt = v.clr;
        b0.wren_a = v.wa; b0.rden_a = v.ra; b0.address_a = v.aa;
        b0.byteena_a = v.bea; b0.data_a = v.da;
        b0.wren_b = v.wb; b0.rden_b = v.rb; b0.address_b = v.ab;
        b0.byteena_b = v.beb; b0.data_b = v.db;
    endtask

    function automatic logic [127:0] snap0();
        return 128'({b0.q_a, b0.q_valid_a, b0.err_a, b0.q_b, b0.q_valid_b,
                     b0.err_b, b0.coll_pulse, b0.coll_cnt});
    endfunction

    function automatic logic [127:0] snap1();
        return 128'({b1.q_a, b1.q_valid_a, b1.err_a, b1.q_b, b1.q_valid_b,
                     b1.err_b, b1.coll_pulse, b1.coll_cnt});
    endfunction

    function automatic logic [127:0] want(input vec_t v);
        return 128'({v.eqa, v.eva, v.eea, v.eqb, v.evb, v.eeb, v.ecp, v.ecnt});
    endfunction

    initial begin
        int nqv;
        //       clr wa ra aa      bea   da            wb rb ab      beb   db
        //       eqa           eva eea eqb           evb eeb cp cnt
        vt[0]  = '{0,0,0,10'd0,  4'h0,32'h0,        0,0,10'd0,  4'h0,32'h0,
                   32'h0,        0,0,32'h0,        0,0,0,16'd0};
        vt[1]  = '{0,1,0,10'd5,  4'hF,32'hDEADBEEF, 0,0,10'd0,  4'h0,32'h0,
                   32'h0,        0,0,32'h0,        0,0,0,16'd0};
        vt[2]  = '{0,0,1,10'd5,  4'h0,32'h0,        0,1,10'd5,  4'h0,32'h0,
                   32'hDEADBEEF, 1,0,32'hDEADBEEF, 1,0,0,16'd0};
        vt[3]  = '{0,1,0,10'd3,  4'hF,32'h11223344, 0,0,10'd0,  4'h0,32'h0,
                   32'hDEADBEEF, 0,0,32'hDEADBEEF, 0,0,0,16'd0};
        vt[4]  = '{0,1,0,10'd3,  4'h5,32'hAABBCCDD, 0,0,10'd0,  4'h0,32'h0,
                   32'hDEADBEEF, 0,0,32'hDEADBEEF, 0,0,0,16'd0};
        vt[5]  = '{0,0,1,10'd3,  4'h0,32'h0,        0,0,10'd0,  4'h0,32'h0,
                   32'h11BB33DD, 1,0,32'hDEADBEEF, 0,0,0,16'd0};
        vt[6]  = '{0,1,0,10'd7,  4'hF,32'h0,        0,0,10'd0,  4'h0,32'h0,
                   32'h11BB33DD, 0,0,32'hDEADBEEF, 0,0,0,16'd0};
        vt[7]  = '{0,1,0,10'd7,  4'h3,32'h000000AA, 1,0,10'd7,  4'h6,32'hBBBBBBBB,
                   32'h11BB33DD, 0,0,32'hDEADBEEF, 0,0,1,16'd1};
        vt[8]  = '{0,0,0,10'd0,  4'h0,32'h0,        0,1,10'd7,  4'h0,32'h0,
                   32'h11BB33DD, 0,0,32'h00BB00AA, 1,0,0,16'd1};
        vt[9]  = '{0,1,0,10'd9,  4'hF,32'h1,        0,0,10'd0,  4'h0,32'h0,
                   32'h11BB33DD, 0,0,32'h00BB00AA, 0,0,0,16'd1};
        vt[10] = '{0,0,1,10'd9,  4'h0,32'h0,        1,0,10'd9,  4'hF,32'h2,
                   32'h1,        1,0,32'h00BB00AA, 0,0,0,16'd1};
        vt[11] = '{0,0,1,10'd9,  4'h0,32'h0,        0,0,10'd0,  4'h0,32'h0,
                   32'h2,        1,0,32'h00BB00AA, 0,0,0,16'd1};
        vt[12] = '{0,1,0,10'd1000,4'hF,32'hFFFFFFFF,0,0,10'd0,  4'h0,32'h0,
                   32'h2,        0,1,32'h00BB00AA, 0,0,0,16'd1};
        vt[13] = '{0,0,1,10'd1023,4'h0,32'h0,       0,0,10'd0,  4'h0,32'h0,
                   32'h0,        1,1,32'h00BB00AA, 0,0,0,16'd1};
        vt[14] = '{0,1,1,10'd1000,4'hF,32'h5,       0,0,10'd0,  4'h0,32'h0,
                   32'h0,        1,1,32'h00BB00AA, 0,0,0,16'd1};
        vt[15] = '{0,0,0,10'd0,  4'h0,32'h0,        0,0,10'd0,  4'h0,32'h0,
                   32'h0,        0,0,32'h00BB00AA, 0,0,0,16'd1};
        vt[16] = '{0,1,0,10'd999,4'h0,32'hFF,       1,0,10'd999,4'hF,32'h12345678,
                   32'h0,        0,0,32'h00BB00AA, 0,0,0,16'd1};
        vt[17] = '{0,0,1,10'd999,4'h0,32'h0,        0,0,10'd0,  4'h0,32'h0,
                   32'h12345678, 1,0,32'h00BB00AA, 0,0,0,16'd1};
        vt[18] = '{0,1,0,10'd7,  4'h0,32'hFF,       1,0,10'd7,  4'h0,32'hFF,
                   32'h12345678, 0,0,32'h00BB00AA, 0,0,0,16'd1};
        vt[19] = '{0,1,0,10'd7,  4'h1,32'h11,       1,0,10'd7,  4'h1,32'h22,
                   32'h12345678, 0,0,32'h00BB00AA, 0,0,1,16'd2};
        vt[20] = '{0,0,1,10'd7,  4'h0,32'h0,        0,1,10'd7,  4'h0,32'h0,
                   32'h00BB0011, 1,0,32'h00BB0011, 1,0,0,16'd2};
        vt[21] = '{1,0,0,10'd0,  4'h0,32'h0,        0,0,10'd0,  4'h0,32'h0,
                   32'h00BB0011, 0,0,32'h00BB0011, 0,0,0,16'd0};
        vt[22] = '{0,0,0,10'd0,  4'h0,32'h0,        1,1,10'd1000,4'hF,32'h9,
                   32'h00BB0011, 0,0,32'h0,        1,1,0,16'd0};

        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold0", snap0(), 128'd0);
        chk("rst_hold1", snap1(), 128'd0);
        @(negedge clk);
        r0 = 1'b1;
        r1 = 1'b1;

        for (int k = 0; k < 23; k++) begin
            put0(vt[k]);
            tick();
            chk($sformatf("vec%0d", k), snap0(), want(vt[k]));
        end

        // Saturation: 65535 collisions reach the ceiling, one more holds it
        for (int k = 0; k < 65535; k++) begin
            b0.wren_a = 1; b0.address_a = 10'd7; b0.byteena_a = 4'h1;
            b0.wren_b = 1; b0.address_b = 10'd7; b0.byteena_b = 4'h1;
            tick();
        end
        chk("sat_reach", 128'(b0.coll_cnt), 128'(16'hFFFF));
        b0.wren_a = 1; b0.address_a = 10'd7; b0.byteena_a = 4'h1;
        b0.wren_b = 1; b0.address_b = 10'd7; b0.byteena_b = 4'h1;
        tick();
        chk("sat_hold", 128'({b0.coll_pulse, b0.coll_cnt}), 128'({1'b1, 16'hFFFF}));
        b0.wren_a = 1; b0.address_a = 10'd7; b0.byteena_a = 4'h1;
        b0.wren_b = 1; b0.address_b = 10'd7; b0.byteena_b = 4'h1;
        b0.clr_coll_cnt = 1;
        tick();
        chk("clr_prio", 128'({b0.coll_pulse, b0.coll_cnt}), 128'({1'b1, 16'h0}));
        tick();
        chk("pulse_one", 128'({b0.coll_pulse, b0.coll_cnt}), 128'({1'b0, 16'h0}));

        // Second instance: two-cycle latency, new-data RDW, B wins collisions
        for (int k = 0; k < 3; k++) begin
            b1.wren_b = 1; b1.address_b = 10'(k); b1.byteena_b = 4'hF;
            b1.data_b = 32'h100 + 32'(k);
            tick();
        end
        b1.wren_a = 1; b1.address_a = 10'd7; b1.byteena_a = 4'hF; b1.data_a = 0;
        tick();
        b1.wren_a = 1; b1.address_a = 10'd7; b1.byteena_a = 4'h3;
        b1.data_a = 32'h000000AA;
        b1.wren_b = 1; b1.address_b = 10'd7; b1.byteena_b = 4'h6;
        b1.data_b = 32'hBBBBBBBB;
        tick();
        chk("coll_b", 128'({b1.coll_pulse, b1.coll_cnt}), 128'({1'b1, 16'd1}));
        b1.wren_a = 1; b1.address_a = 10'd9; b1.byteena_a = 4'hF; b1.data_a = 1;
        tick();
        b1.rden_a = 1; b1.address_a = 10'd9;
        b1.wren_b = 1; b1.address_b = 10'd9; b1.byteena_b = 4'hF; b1.data_b = 2;
        tick();
        chk("lat2_wait", 128'(b1.q_valid_a), 128'(1'b0));
        tick();
        chk("rdw_new", 128'({b1.q_a, b1.q_valid_a}), 128'({32'h2, 1'b1}));
        b1.rden_a = 1; b1.address_a = 10'd7;
        tick();
        tick();
        chk("prio_b", 128'({b1.q_a, b1.q_valid_a}), 128'({32'h00BBBBAA, 1'b1}));
        tick();
        chk("hold_one", 128'({b1.q_a, b1.q_valid_a}), 128'({32'h00BBBBAA, 1'b0}));

        b1.rden_a = 1; b1.address_a = 10'd0;
        tick();
        chk("pipe_e1", 128'(b1.q_valid_a), 128'(1'b0));
        b1.rden_a = 1; b1.address_a = 10'd1;
        tick();
        chk("pipe_e2", 128'({b1.q_a, b1.q_valid_a}), 128'({32'h100, 1'b1}));
        b1.rden_a = 1; b1.address_a = 10'd2;
        tick();
        chk("pipe_e3", 128'({b1.q_a, b1.q_valid_a}), 128'({32'h101, 1'b1}));
        r1 = 1'b0;
        #1;
        chk("rst_clear", snap1(), 128'd0);
        tick();
        tick();
        @(negedge clk);
        r1 = 1'b1;
        nqv = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            nqv += int'(b1.q_valid_a);
        end
        chk("no_qv_after_rst", 128'(nqv), 128'(0));
        b1.rden_a = 1; b1.address_a = 10'd1;
        tick();
        tick();
        chk("mem_survive", 128'({b1.q_a, b1.q_valid_a}), 128'({32'h101, 1'b1}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
